// File: rtl/piso_ser.sv
// ============================================================================
// piso_ser : parametrised serializer with serial-clock generation and readback
// Rev 1.0  : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module piso_ser #(
   parameter int WIDTH     = 32,
   parameter int CLK_DIV   = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             xmit,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sdi,
   output logic             data_out,
   output logic             clk_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rb_data
);

   localparam int c_cw    = $clog2(WIDTH + 1);
   localparam int c_pw    = $clog2(CLK_DIV);
   localparam int c_first = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_low  = 2'd1;
   localparam logic [1:0] c_high = 2'd2;
   localparam logic [1:0] c_done = 2'd3;

   localparam logic [c_pw-1:0] c_half_m1 = c_pw'(CLK_DIV / 2 - 1);
   localparam logic [c_cw-1:0] c_last    = c_cw'(WIDTH - 1);

   generate
      if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0) || (WIDTH < 1)) begin : g_param_check
         $error("piso_ser: CLK_DIV must be even and >= 2, WIDTH >= 1");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             r_xmit_q;
   logic             r_armed;
   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] r_tx;
   logic [WIDTH-1:0] r_rx;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] w_tx_shift;
   logic [WIDTH-1:0] w_rx_shift;
   logic [WIDTH-1:0] w_word;
   logic [c_cw-1:0]  r_bit;
   logic [c_pw-1:0]  r_phase;
   logic             w_start;
   logic             w_phase_end;
   logic             w_last;

   // Transmit shifts toward the outgoing end; readback enters at the far end so
   // after WIDTH samples each bit sits where its transmitted counterpart came from.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (MSB_FIRST != 0) begin : g_msb
            if (i == 0) begin : g_end
               assign w_tx_shift[i] = 1'b0;
               assign w_rx_shift[i] = sdi;
            end else begin : g_mid
               assign w_tx_shift[i] = r_tx[i-1];
               assign w_rx_shift[i] = r_rx[i-1];
            end
         end else begin : g_lsb
            if (i == WIDTH - 1) begin : g_end
               assign w_tx_shift[i] = 1'b0;
               assign w_rx_shift[i] = sdi;
            end else begin : g_mid
               assign w_tx_shift[i] = r_tx[i+1];
               assign w_rx_shift[i] = r_rx[i+1];
            end
         end
      end
   endgenerate

   // r_armed blocks a start until xmit has been seen low after reset.
   assign w_start     = xmit & ~r_xmit_q & r_armed & (r_state == c_idle);
   assign w_word      = load ? data_in : r_shadow;
   assign w_phase_end = (r_phase == c_half_m1);
   assign w_last      = (r_bit == c_last);
   assign rb_data     = r_rb;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:  if (w_start) w_next = c_low;
         c_low:   if (w_phase_end) w_next = c_high;
         c_high:  if (w_phase_end) w_next = w_last ? c_done : c_low;
         default: w_next = c_idle;
      endcase
   end

   always_comb begin
      busy     = (r_state == c_low) || (r_state == c_high);
      clk_out  = (r_state == c_high);
      done     = (r_state == c_done);
      data_out = busy ? r_tx[c_first] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_xmit_q <= 1'b0;
         r_armed  <= 1'b0;
         r_shadow <= '0;
         r_tx     <= '0;
         r_rx     <= '0;
         r_rb     <= '0;
         r_bit    <= '0;
         r_phase  <= '0;
      end else begin
         r_xmit_q <= xmit;
         if (!xmit) r_armed <= 1'b1;
         if (load) r_shadow <= data_in;
         case (r_state)
            c_idle: begin
               if (w_start) begin
                  r_tx    <= w_word;
                  r_bit   <= '0;
                  r_phase <= '0;
               end
            end
            c_low: begin
               if (w_phase_end) begin
                  r_phase <= '0;
                  r_rx    <= w_rx_shift;
               end else begin
                  r_phase <= r_phase + c_pw'(1);
               end
            end
            c_high: begin
               if (w_phase_end) begin
                  r_phase <= '0;
                  if (w_last) begin
                     r_rb <= r_rx;
                  end else begin
                     r_bit <= r_bit + c_cw'(1);
                     r_tx  <= w_tx_shift;
                  end
               end else begin
                  r_phase <= r_phase + c_pw'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_piso_ser.sv
// ============================================================================
// tb_piso_ser : scoreboard bench for piso_ser across several parameter sets
// Rev 1.0     : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_piso_ser;

   localparam int NI = 6;

   function automatic int f_w(input int i);
      case (i)
         0, 1:    return 32;
         2, 5:    return 1;
         default: return 7;
      endcase
   endfunction

   function automatic int f_d(input int i);
      case (i)
         0, 1:    return 4;
         3, 5:    return 8;
         default: return 2;
      endcase
   endfunction

   function automatic int f_m(input int i);
      case (i)
         1, 4, 5: return 0;
         default: return 1;
      endcase
   endfunction

   function automatic int f_lb(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        load_v [NI];
   logic        xmit_v [NI];
   logic [31:0] din    [NI];
   wire         so     [NI];
   wire         ck     [NI];
   wire         bs     [NI];
   wire         dn     [NI];
   wire  [31:0] rb     [NI];

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         localparam int W = f_w(g);
         logic [W-1:0] din_w;
         logic [W-1:0] rb_w;
         logic         dout, cko, bsy, dne, sdi_w;
         assign din_w = din[g][W-1:0];
         assign sdi_w = (f_lb(g) != 0) ? dout : 1'b0;
         piso_ser #(.WIDTH(W), .CLK_DIV(f_d(g)), .MSB_FIRST(f_m(g))) u_dut (
            .clk(clk), .rst(rst), .load(load_v[g]), .xmit(xmit_v[g]),
            .data_in(din_w), .sdi(sdi_w), .data_out(dout), .clk_out(cko),
            .busy(bsy), .done(dne), .rb_data(rb_w)
         );
         assign so[g] = dout;
         assign ck[g] = cko;
         assign bs[g] = bsy;
         assign dn[g] = dne;
         assign rb[g] = 32'(rb_w);
      end
   endgenerate

   typedef struct {
      int          id;
      logic [31:0] tx;
      logic [31:0] rb;
      bit          chk4;
      logic [3:0]  f4;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int          total = 0;
   int          bad   = 0;
   int          starts_issued [NI] = '{default: 0};
   int          starts_seen   [NI] = '{default: 0};
   int          done_seen     [NI] = '{default: 0};
   int          rises         [NI] = '{default: 0};
   int          busyc         [NI] = '{default: 0};
   logic [31:0] cap           [NI] = '{default: 32'd0};
   logic [3:0]  f4c           [NI] = '{default: 4'd0};
   logic        pck           [NI] = '{default: 1'b0};
   logic        pbs           [NI] = '{default: 1'b0};
   int          tmo_req = 0;
   int          tmo_seen = 0;
   bit          fin_req = 1'b0;
   bit          fin_ack = 1'b0;
   logic        rst_last = 1'b1;

   always @(posedge clk) rst_last <= rst;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %h expected %h", nm, i, act, exp);
      end
   endtask

   // Monitor: tracks each DUT's transfer and retires scoreboard entries on done.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_last) begin
            chk("reset_outputs", i, {28'd0, bs[i], dn[i], ck[i], so[i]}, 32'd0);
            chk("reset_rb_data", i, rb[i], 32'd0);
            pck[i] = 1'b0;
            pbs[i] = 1'b0;
         end else begin
            if (bs[i] && !pbs[i]) begin
               starts_seen[i]++;
               chk("start_expected", i, 32'(starts_issued[i] >= starts_seen[i]), 32'd1);
               rises[i] = 0;
               busyc[i] = 0;
               cap[i]   = 32'd0;
               f4c[i]   = 4'd0;
            end
            if (bs[i]) busyc[i]++;
            if (ck[i] && !pck[i]) begin
               if (rises[i] < f_w(i))
                  cap[i][(f_m(i) != 0) ? f_w(i) - 1 - rises[i] : rises[i]] = so[i];
               if (rises[i] < 4) f4c[i] = {f4c[i][2:0], so[i]};
               rises[i]++;
            end
            if (dn[i]) begin
               done_seen[i]++;
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done dut%0d: got done pulse expected none", i);
               end else begin
                  e = sb.pop_front();
                  chk("sb_id", i, 32'(i), 32'(e.id));
                  chk("tx_word", i, cap[i], e.tx);
                  chk("rb_data", i, rb[i], e.rb);
                  chk("rise_count", i, 32'(rises[i]), 32'(f_w(i)));
                  chk("busy_cycles", i, 32'(busyc[i]), 32'(f_w(i) * f_d(i)));
                  chk("done_pins", i, {29'd0, bs[i], ck[i], so[i]}, 32'd0);
                  if (e.chk4) chk("first_four", i, {28'd0, f4c[i]}, {28'd0, e.f4});
               end
            end
            pck[i] = ck[i];
            pbs[i] = bs[i];
         end
      end
      if (tmo_req != tmo_seen) begin
         tmo_seen = tmo_req;
         total++;
         bad++;
         $display("FAIL timeout: got no completion expected done within budget");
      end
      if (fin_req && !fin_ack) begin
         chk("sb_empty", 0, 32'(sb.size()), 32'd0);
         fin_ack = 1'b1;
      end
   end

   task automatic issue(input int i, input logic [31:0] w, input bit do_load, input bit same,
                        input logic [31:0] etx, input logic [31:0] erb, input bit c4, input logic [3:0] f4);
      exp_t x;
      x.id = i; x.tx = etx; x.rb = erb; x.chk4 = c4; x.f4 = f4;
      sb.push_back(x);
      starts_issued[i]++;
      @(posedge clk); #2;
      if (do_load) begin
         din[i]    = w;
         load_v[i] = 1'b1;
      end
      if (do_load && !same) begin
         @(posedge clk); #2;
         load_v[i] = 1'b0;
      end
      xmit_v[i] = 1'b1;
      @(posedge clk); #2;
      load_v[i] = 1'b0;
      xmit_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int tgt = done_seen[i] + 1;
      int c   = 0;
      while (done_seen[i] < tgt && c < f_w(i) * f_d(i) + 50) begin
         @(posedge clk);
         c++;
      end
      if (done_seen[i] < tgt) tmo_req++;
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_rises(input int i, input int n);
      int c = 0;
      while (rises[i] < n && c < 2000) begin
         @(posedge clk);
         c++;
      end
      if (rises[i] < n) tmo_req++;
   endtask

   initial begin
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         load_v[i] = 1'b0;
         xmit_v[i] = 1'b1;
         din[i]    = 32'd0;
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      // xmit still high: nothing may start until it drops and rises again.
      repeat (20) @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) xmit_v[i] = 1'b0;
      repeat (3) @(posedge clk);

      issue(0, 32'h1db6ff8b, 1, 0, 32'h1db6ff8b, 32'h1db6ff8b, 1, 4'b0001);
      wait_done(0);
      issue(1, 32'h1db6ff8b, 1, 0, 32'h1db6ff8b, 32'h00000000, 1, 4'b1101);
      wait_done(1);

      issue(0, 32'h0f0f3c3c, 1, 0, 32'h0f0f3c3c, 32'h0f0f3c3c, 0, 4'd0);
      wait_rises(0, 5);
      @(posedge clk); #2;
      din[0]    = 32'hffffffff;
      load_v[0] = 1'b1;
      xmit_v[0] = 1'b1;
      @(posedge clk); #2;
      load_v[0] = 1'b0;
      xmit_v[0] = 1'b0;
      wait_done(0);
      repeat (10) @(posedge clk);
      issue(0, 32'h0, 0, 0, 32'hffffffff, 32'hffffffff, 0, 4'd0);
      wait_done(0);
      issue(0, 32'h0000a5a5, 1, 1, 32'h0000a5a5, 32'h0000a5a5, 0, 4'd0);
      wait_done(0);

      // Transfer aborted by reset: no scoreboard entry, so any done is flagged.
      starts_issued[0]++;
      @(posedge clk); #2 xmit_v[0] = 1'b1;
      @(posedge clk); #2 xmit_v[0] = 1'b0;
      wait_rises(0, 10);
      #2 rst = 1'b0;
      @(posedge clk); #2 rst = 1'b1;
      repeat (10) @(posedge clk);
      issue(0, 32'h600dcafe, 1, 0, 32'h600dcafe, 32'h600dcafe, 0, 4'd0);
      wait_done(0);

      issue(2, 32'h1,  1, 0, 32'h1,  32'h1,  0, 4'd0); wait_done(2);
      issue(2, 32'h0,  1, 0, 32'h0,  32'h0,  0, 4'd0); wait_done(2);
      issue(3, 32'h4b, 1, 0, 32'h4b, 32'h4b, 0, 4'd0); wait_done(3);
      issue(4, 32'h35, 1, 0, 32'h35, 32'h35, 0, 4'd0); wait_done(4);
      issue(5, 32'h1,  1, 0, 32'h1,  32'h1,  0, 4'd0); wait_done(5);

      fin_req = 1'b1;
      for (int c = 0; c < 10 && !fin_ack; c++) @(posedge clk);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/piso_ser.md
Name: piso_ser

Overview:
- Parametrised serializer with readback for loading ASIC configuration shift chains. It is the successor of the fixed 32-bit load/xmit PISO.
- Captures a WIDTH-bit word and, on an xmit edge, shifts exactly WIDTH bits out with a generated serial clock.
- Simultaneously shifts the chain's return bit back in, so software can verify the chain contents.
- Sits between the register bank (reg_rw) and the ASIC serial pins in top_rtl.

Parameters:
- WIDTH, 32, word length in bits (>=1).
- CLK_DIV, 2, serial clock period in clk cycles; must be even and >=2, otherwise elaboration fails.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous reset, active-low
- load  in  1  level; while high, shadow <= data_in each clk
- xmit  in  1  transfer start; only the rising edge acts
- data_in  in  WIDTH  parallel word
- sdi  in  1  serial return from the chain
- data_out  out  1  serial data to the chain
- clk_out  out  1  serial clock to the chain
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at the end of a transfer
- rb_data  out  WIDTH  last word read back, in the same bit order as data_in

Behaviour:
- Reset (rst=0 at a clk edge): all state and outputs go to 0, including shadow, shift register, rb_data and the xmit edge register. This applies mid-transfer: clk_out and data_out drop to 0 on that edge, and no done pulse is produced.
- Edge detect: xmit_q is registered. A start is xmit & ~xmit_q while in IDLE.
  - Holding xmit high produces exactly one transfer.
  - Start edges while busy are ignored. They are not queued.
- load:
  - Writes the shadow register only.
  - load while busy does not affect the current transfer.
  - If load and a start occur in the same cycle, the transfer sends data_in from that cycle (bypass).
- FSM states: IDLE, LOW, HIGH, DONE. H = CLK_DIV/2.
  - IDLE -> LOW on start (clk edge k). At edge k:
    - shift register <= word;
    - data_out <= first bit;
    - busy <= 1;
    - clk_out = 0;
    - bit counter <= 0.
  - LOW:
    - clk_out = 0 for H cycles;
    - then -> HIGH, clk_out <= 1;
    - on that same edge sdi is shifted into the readback register.
  - HIGH:
    - clk_out = 1 for H cycles;
    - if bit counter = WIDTH-1: -> DONE;
    - else: increment counter, -> LOW, clk_out <= 0, data_out <= next bit.
    - data_out changes only on clk_out falling transitions, which gives H cycles of setup and hold around each rising transition.
  - DONE (one cycle, entered at edge k+WIDTH*CLK_DIV):
    - busy = 0, done = 1, clk_out = 0, data_out = 0;
    - rb_data <= assembled readback word;
    - -> IDLE on the next edge, done returns to 0.
- Transfer totals: exactly WIDTH clk_out rising edges. busy is high for exactly WIDTH*CLK_DIV cycles.
- Readback ordering: the bit sampled at rising edge n is placed at the position the transmitted bit n came from. With sdi tied to data_out, rb_data == transmitted word.
- rb_data holds its value until the next DONE or reset.
- Counter width is $clog2(WIDTH+1). There is no wrap-around hazard: the counter stops at WIDTH-1.

Test Plan:
1. Reset/idle:
   - Stimulus: rst=0 for 3 clk with xmit=1.
   - Required: all outputs 0.
   - Stimulus: release rst with xmit still high.
   - Required: no transfer until xmit goes low then high again.
2. MSB-first loopback:
   - Setup: WIDTH=32, CLK_DIV=4, sdi=data_out; load 32'h1db6ff8b, then pulse xmit.
   - Required serial output: first four data_out bits are 0,0,0,1.
   - Required counts: 32 clk_out rises; busy high 128 cycles.
   - Required completion: done pulses once; rb_data=32'h1db6ff8b.
3. LSB-first:
   - Setup: MSB_FIRST=0, same word, sdi=0.
   - Required serial output: first four bits are 1,1,0,1.
   - Required completion: rb_data=32'h0.
4. Collisions:
   - Stimulus A: during a transfer, load 32'hffffffff and pulse xmit.
   - Required A: the current stream is unchanged; no second transfer starts.
   - Stimulus B: a later xmit edge.
   - Required B: sends 32'hffffffff.
   - Stimulus C: same-cycle load+start with data_in=32'h0000a5a5.
   - Required C: sends 32'h0000a5a5.
5. Reset mid-transfer:
   - Stimulus: assert rst after the 10th clk_out rise.
   - Required: clk_out and data_out are 0 on the next edge; no done; rb_data=0.
   - Stimulus: a subsequent transfer.
   - Required: completes normally.
6. Parameter sweep:
   - Setup: WIDTH=1 and WIDTH=7, CLK_DIV=2 and CLK_DIV=8, random words, loopback.
   - Required: rb_data==word; rise count == WIDTH; busy cycles == WIDTH*CLK_DIV.
